// File: rtl/jt89_wrseq.sv
// rtl/jt89_wrseq.sv - SN76489 write-port sequencer: request FIFO feeding a wr_n/din byte serializer
// Requests are queued at clk rate; the serializer only advances on clken ticks.
module jt89_wrseq #(
  parameter int WR_CYCLES  = 2,
  parameter int GAP_CYCLES = 1,
  parameter int AW         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_ch,
  input  logic        req_vol,
  input  logic [9:0]  req_data,
  output logic        wr_n,
  output logic [7:0]  din,
  output logic        busy,
  output logic [AW:0] level
);

  localparam int DEPTH = 1 << AW;
  localparam int CW    = 16;
  localparam logic [CW-1:0] WR_LOAD    = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_GAP1,
    S_DATA,
    S_GAP2
  } state_t;

  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_n_q, wr_n_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    data_byte_q, data_byte_d;
  logic          two_q, two_d;

  logic          full, empty, push, pop;
  logic [12:0]   head;
  logic [1:0]    head_ch;
  logic          head_vol;
  logic [9:0]    head_data;

  always_comb begin
    full      = (level_q == FULL_LEVEL);
    empty     = (level_q == '0);
    push      = req_valid && !full;
    pop       = clken && (state_q == S_IDLE) && !empty;
    head      = mem_q[rd_ptr_q];
    head_ch   = head[12:11];
    head_vol  = head[10];
    head_data = head[9:0];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // The data byte and its two-byte flag are captured at pop time so the FIFO slot is free immediately.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_n_d      = wr_n_q;
    din_d       = din_q;
    data_byte_d = data_byte_q;
    two_d       = two_q;
    if (clken) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            din_d       = {1'b1, head_ch, head_vol, head_data[3:0]};
            data_byte_d = {2'b00, head_data[9:4]};
            two_d       = !head_vol && (head_ch != 2'd3);
            wr_n_d      = 1'b0;
            cnt_d       = WR_LOAD;
            state_d     = S_LATCH;
          end
        end
        S_LATCH, S_DATA: begin
          if (cnt_q == '0) begin
            wr_n_d  = 1'b1;
            cnt_d   = GAP_LOAD;
            state_d = (state_q == S_LATCH) ? S_GAP1 : S_GAP2;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_GAP1: begin
          if (cnt_q == '0) begin
            if (two_q) begin
              din_d   = data_byte_q;
              wr_n_d  = 1'b0;
              cnt_d   = WR_LOAD;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_GAP2: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_ch, req_vol, req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_n_q      <= 1'b1;
      din_q       <= 8'h00;
      data_byte_q <= 8'h00;
      two_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_n_q      <= wr_n_d;
      din_q       <= din_d;
      data_byte_q <= data_byte_d;
      two_q       <= two_d;
    end
  end

  assign req_ready = !full;
  assign wr_n      = wr_n_q;
  assign din       = din_q;
  assign level     = level_q;
  assign busy      = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_jt89_wrseq.sv
// tb/tb_jt89_wrseq.sv - self-checking bench for jt89_wrseq: vector table, corner sequences, random run vs byte-stream model
module tb_jt89_wrseq;

  localparam int WR    = 2;
  localparam int GAP   = 1;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clken;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_ch;
  logic          req_vol;
  logic [9:0]    req_data;
  logic          wr_n;
  logic [7:0]    din;
  logic          busy;
  logic [AW:0]   level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jt89_wrseq #(.WR_CYCLES(WR), .GAP_CYCLES(GAP), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clken(clken),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_vol(req_vol), .req_data(req_data),
    .wr_n(wr_n), .din(din), .busy(busy), .level(level)
  );

  typedef struct {
    logic [1:0] ch;
    logic       vol;
    logic [9:0] data;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         two;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    bit         lat;
  } ev_t;

  vec_t vecs[7];
  ev_t  exp_q[$];
  logic [7:0] got_q[$];

  int   lvl_m, high_ticks, low_ticks, falls;
  bit   prev_wr, ce_edge, acc_edge;
  logic [7:0] prev_din, last_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] latch_byte(input int ch, input int vol, input int data);
    return 8'(128 + ch * 32 + vol * 16 + data % 16);
  endfunction

  task automatic push_req(input int ch, input int vol, input int data);
    exp_q.push_back('{latch_byte(ch, vol, data), 1'b1});
    if (vol == 0 && ch < 3) exp_q.push_back('{8'(data / 16), 1'b0});
  endtask

  task automatic drive_req(input logic [1:0] ch, input logic vol, input logic [9:0] data);
    req_valid = 1'b1;
    req_ch    = ch;
    req_vol   = vol;
    req_data  = data;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    clken     = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic detect_fall();
    if (prev_wr && !wr_n) begin
      falls++;
      last_byte = din;
    end
    prev_wr = wr_n;
  endtask

  task automatic rand_step(input bit drain);
    ev_t e;
    bit  fall, rise;
    if (drain) begin
      clken     = 1'b1;
      req_valid = 1'b0;
    end else begin
      clken     = ($urandom_range(0, 3) != 0);
      req_valid = 1'($urandom_range(0, 1));
      req_ch    = 2'($urandom_range(0, 3));
      req_vol   = 1'($urandom_range(0, 1));
      req_data  = 10'($urandom_range(0, 1023));
    end
    acc_edge = req_valid && req_ready;
    ce_edge  = clken;
    if (acc_edge) push_req(int'(req_ch), int'(req_vol), int'(req_data));
    prev_wr  = wr_n;
    prev_din = din;
    @(negedge clk);
    fall = ce_edge && prev_wr && !wr_n;
    rise = ce_edge && !prev_wr && wr_n;
    if (!ce_edge) begin
      check("rand hold without clken", {wr_n, din}, {prev_wr, prev_din});
    end else if (fall) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rand unexpected byte: got 0x%0h want none", din);
      end else begin
        e = exp_q.pop_front();
        check("rand byte", din, e.b);
        if (e.lat) begin
          total++;
          if (high_ticks < GAP + 1) begin
            bad++;
            $display("FAIL rand latch gap: got %0d want >=%0d", high_ticks, GAP + 1);
          end
          lvl_m--;
        end else begin
          check("rand data gap", high_ticks, GAP);
        end
      end
      low_ticks = 1;
    end else begin
      check("rand din stable", din, prev_din);
      if (rise) begin
        check("rand low width", low_ticks, WR);
        high_ticks = 1;
      end else if (!wr_n) begin
        low_ticks++;
      end else if (high_ticks < 1000) begin
        high_ticks++;
      end
    end
    if (acc_edge) lvl_m++;
    check("rand level", level, lvl_m);
    check("rand req_ready", req_ready, lvl_m < DEPTH);
    check("rand busy", busy, (lvl_m != 0) || !wr_n || (high_ticks <= GAP));
  endtask

  initial begin
    bit         busy_e, wr_e;
    logic [7:0] din_e;
    int         busy_end;

    vecs[0] = '{2'd1, 1'b0, 10'h2AB, 8'hAB, 8'h2A, 1'b1};
    vecs[1] = '{2'd2, 1'b1, 10'h00F, 8'hDF, 8'h00, 1'b0};
    vecs[2] = '{2'd3, 1'b0, 10'h3F5, 8'hE5, 8'h00, 1'b0};
    vecs[3] = '{2'd0, 1'b0, 10'h3FF, 8'h8F, 8'h3F, 1'b1};
    vecs[4] = '{2'd0, 1'b1, 10'h3A7, 8'h97, 8'h00, 1'b0};
    vecs[5] = '{2'd3, 1'b1, 10'h002, 8'hF2, 8'h00, 1'b0};
    vecs[6] = '{2'd2, 1'b0, 10'h150, 8'hC0, 8'h15, 1'b1};

    rst = 1'b1; clken = 1'b1; req_valid = 1'b0;
    req_ch = '0; req_vol = 1'b0; req_data = '0;
    #1;
    check("reset outputs during rst", {wr_n, din, req_ready, level, busy}, {1'b1, 8'h00, 1'b1, 3'd0, 1'b0});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("idle cycle %0d", c), {wr_n, din, req_ready, level, busy},
            {1'b1, 8'h00, 1'b1, 3'd0, 1'b0});
    end

    for (int i = 0; i < 7; i++) begin
      drive_req(vecs[i].ch, vecs[i].vol, vecs[i].data);
      @(negedge clk);
      req_valid = 1'b0;
      check($sformatf("vec%0d queued", i), {wr_n, level, busy}, {1'b1, 3'd1, 1'b1});
      busy_end = vecs[i].two ? 2 * WR + 2 * GAP : WR + GAP;
      for (int k = 1; k <= 9; k++) begin
        @(negedge clk);
        if (k <= WR)                              begin wr_e = 1'b0; din_e = vecs[i].b0; end
        else if (!vecs[i].two || k <= WR + GAP)   begin wr_e = 1'b1; din_e = vecs[i].b0; end
        else if (k <= 2 * WR + GAP)               begin wr_e = 1'b0; din_e = vecs[i].b1; end
        else                                      begin wr_e = 1'b1; din_e = vecs[i].b1; end
        busy_e = (k <= busy_end);
        check($sformatf("vec%0d k%0d busy/wr_n/din", i, k), {busy, wr_n, din}, {busy_e, wr_e, din_e});
      end
    end

    // Fill with clken low, try an overflow push, then release and check order
    exp_q.delete();
    clken = 1'b0;
    drive_req(2'd0, 1'b1, 10'h005); push_req(0, 1, 'h005); @(negedge clk);
    drive_req(2'd1, 1'b0, 10'h123); push_req(1, 0, 'h123); @(negedge clk);
    drive_req(2'd3, 1'b0, 10'h004); push_req(3, 0, 'h004); @(negedge clk);
    drive_req(2'd2, 1'b1, 10'h00A); push_req(2, 1, 'h00A); @(negedge clk);
    check("full level", level, 4);
    check("full req_ready", req_ready, 0);
    check("full wr_n held", wr_n, 1);
    drive_req(2'd0, 1'b1, 10'h00C);
    @(negedge clk);
    req_valid = 1'b0;
    check("overflow level", level, 4);
    clken = 1'b1;
    prev_wr = wr_n;
    got_q.delete();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (prev_wr && !wr_n) got_q.push_back(din);
      prev_wr = wr_n;
    end
    check("fifo byte count", got_q.size(), exp_q.size());
    for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
      check($sformatf("fifo byte %0d", j), got_q[j], exp_q[j].b);
    check("fifo drained", {level, busy, req_ready}, {3'd0, 1'b0, 1'b1});

    // Reset during the data byte of a tone, with another request pending
    do_reset();
    falls = 0; prev_wr = 1'b1;
    drive_req(2'd0, 1'b0, 10'h3C1);
    @(negedge clk); detect_fall();
    drive_req(2'd1, 1'b1, 10'h003);
    @(negedge clk); detect_fall();
    req_valid = 1'b0;
    for (int c = 0; c < 30 && falls < 2; c++) begin
      @(negedge clk); detect_fall();
    end
    check("rst test reached data byte", falls, 2);
    check("rst test data byte", {wr_n, din, level}, {1'b0, 8'h3C, 3'd1});
    rst = 1'b1;
    #1;
    check("async reset outputs", {wr_n, din, level, busy, req_ready}, {1'b1, 8'h00, 3'd0, 1'b0, 1'b1});
    @(negedge clk);
    rst = 1'b0;
    falls = 0; prev_wr = wr_n;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); detect_fall();
    end
    check("no bytes after reset", falls, 0);
    drive_req(2'd2, 1'b1, 10'h007);
    @(negedge clk); detect_fall();
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); detect_fall();
    end
    check("post-reset single write", {falls[7:0], last_byte}, {8'd1, 8'hD7});

    // Randomized traffic against the byte-stream model
    do_reset();
    exp_q.delete();
    lvl_m = 0; high_ticks = 1000; low_ticks = 0;
    for (int c = 0; c < 3000; c++) rand_step(1'b0);
    for (int c = 0; c < 100; c++) rand_step(1'b1);
    check("rand all bytes emitted", exp_q.size(), 0);
    check("rand idle at end", {busy, level}, {1'b0, 3'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt89_wrseq.md
Name: jt89_wrseq

Overview:
Write-side sequencer for the jt89 PSG core. It accepts register-level requests (channel, tone or attenuation, value) through a valid/ready handshake and buffers them in a small FIFO. It serializes each request into SN76489 bus bytes on wr_n/din, with programmable strobe and gap timing. It sits between a CPU or sound-driver model and the jt89 write port.

Parameters:
WR_CYCLES, 2, clken ticks that wr_n is held low per byte (legal values ≥1)
GAP_CYCLES, 1, clken ticks that wr_n is held high after each byte (legal values ≥1)
AW, 2, FIFO address width; depth = 2**AW entries

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
clken  input  1  clock enable for the bus serializer (same tick as jt89 clken)
req_valid  input  1  request present
req_ready  output  1  FIFO can accept; a transfer occurs when req_valid && req_ready at a clk edge
req_ch  input  2  channel: 0–2 tone, 3 noise
req_vol  input  1  1 = attenuation write, 0 = tone period / noise control
req_data  input  10  value; tone uses [9:0], attenuation and noise use [3:0]
wr_n  output  1  PSG write strobe, active low
din  output  8  PSG data bus
busy  output  1  FSM not idle or FIFO not empty
level  output  AW+1  FIFO occupancy

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values: wr_n=1, din=0, level=0, busy=0, req_ready=1, FSM=IDLE, FIFO pointers cleared.
- FIFO push/pop:
  - Push is independent of clken.
  - req_ready = !full. When full, no push occurs, even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-empty FIFO leaves level unchanged.
  - Entries leave in strict arrival order.
  - Pointers wrap modulo 2**AW.
- Byte formation:
  - Latch byte = {1, req_ch, req_vol, req_data[3:0]}.
  - Two-byte request: req_vol=0 and req_ch<3. Second byte = {2'b00, req_data[9:4]}.
  - All other requests are single-byte; req_data[9:4] is ignored.
- FSM advances only on clk edges where clken=1. When clken=0, state, counters, wr_n and din hold.
  - IDLE, FIFO not empty: pop; din<=latch byte; wr_n<=0; cnt<=WR_CYCLES-1; go to LATCH.
  - LATCH: if cnt==0, wr_n<=1, cnt<=GAP_CYCLES-1, go to GAP1; else cnt--.
  - GAP1: if cnt==0, then for a two-byte request din<=data byte, wr_n<=0, cnt<=WR_CYCLES-1, go to DATA; otherwise go to IDLE. Else cnt--.
  - DATA: same as LATCH, but goes to GAP2.
  - GAP2: if cnt==0, go to IDLE; else cnt--.
- din holds each byte stable for the whole low pulse and the following gap. It changes only on the tick wr_n falls.
- Timing with clken tied to 1:
  - Single-byte request: WR_CYCLES low, then GAP_CYCLES+1 high before the next falling edge.
  - Two-byte request: 2·WR_CYCLES + 2·GAP_CYCLES + 1 cycles from one falling edge of a latch byte to the next latch byte.
- Latency: with an empty FIFO in IDLE, a request accepted at edge N gives wr_n=0 at edge N+1 (if clken=1 at N+1).
- busy = (state!=IDLE) || (level!=0).
- Reset asserted mid-operation (any state): wr_n returns to 1 and din to 0 immediately. The FIFO is emptied and the partial request is discarded; no data byte is ever emitted without its latch byte.

Test Plan:
1. Reset with no requests, clken=1 → wr_n=1, din=0x00, req_ready=1, level=0, busy=0 for 20 cycles.
2. Tone: ch=1, vol=0, data=0x2AB, clken=1 → din=0xAB with wr_n low 2 cycles, high 1 cycle; then din=0x2A with wr_n low 2 cycles; busy falls after GAP2.
3. Attenuation: ch=2, vol=1, data=0x00F → single write, din=0xDF, wr_n low exactly 2 cycles, no second byte.
4. Noise: ch=3, vol=0, data=0x3F5 → single write, din=0xE5; upper bits ignored.
5. Push 4 requests with clken=0 → level=4, req_ready=0, and a 5th valid is not accepted. Raise clken → four byte sequences on din, in order.
6. Push a tone, assert rst during DATA → wr_n=1 and din=0 the same cycle, level=0, busy=0. After release, a new volume request emits only its latch byte.
